// File: rtl/udp_tx_framer.sv
// Frames a command plus an unframed 32-bit word stream into a udp_sink packet:
// latched header fields, last on the final beat and a one-hot last_be.
module udp_tx_framer #(
  parameter int unsigned MAX_LENGTH = 1472
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_ip_address,
  input  logic [15:0] cmd_dst_port,
  input  logic [15:0] cmd_src_port,
  input  logic [15:0] cmd_length,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data,
  output logic        udp_sink_valid,
  input  logic        udp_sink_ready,
  output logic [31:0] udp_sink_data,
  output logic        udp_sink_last,
  output logic [3:0]  udp_sink_last_be,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_dst_port,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_length,
  output logic        busy,
  output logic        cmd_error
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t      state, state_next;
  logic [15:0] beats_left;
  logic [3:0]  final_be;

  logic        cmd_fire, data_fire, out_fire, cmd_bad, final_beat;
  logic [16:0] len_plus3;
  logic [15:0] cmd_beats;
  logic [1:0]  be_idx;
  logic [3:0]  cmd_be;

  assign cmd_bad    = (cmd_length == 16'd0) || ({16'd0, cmd_length} > MAX_LENGTH);
  assign len_plus3  = {1'b0, cmd_length} + 17'd3;
  assign cmd_beats  = {1'b0, len_plus3[16:2]};
  assign be_idx     = cmd_length[1:0] - 2'd1;
  assign cmd_be     = 4'b0001 << be_idx;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign data_fire  = data_valid && data_ready;
  assign out_fire   = udp_sink_valid && udp_sink_ready;
  assign final_beat = (beats_left == 16'd1);
  assign busy       = (state != IDLE);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_bad) state_next = STREAM;
      end
      STREAM: begin
        // Single output register: refill in the same cycle the beat drains.
        data_ready = !udp_sink_valid || udp_sink_ready;
        if (data_fire && final_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state               <= IDLE;
      beats_left          <= '0;
      final_be            <= '0;
      cmd_error           <= 1'b0;
      udp_sink_valid      <= 1'b0;
      udp_sink_data       <= '0;
      udp_sink_last       <= 1'b0;
      udp_sink_last_be    <= '0;
      udp_sink_ip_address <= '0;
      udp_sink_dst_port   <= '0;
      udp_sink_src_port   <= '0;
      udp_sink_length     <= '0;
    end else begin
      state     <= state_next;
      cmd_error <= cmd_fire && cmd_bad;

      if (cmd_fire && !cmd_bad) begin
        udp_sink_ip_address <= cmd_ip_address;
        udp_sink_dst_port   <= cmd_dst_port;
        udp_sink_src_port   <= cmd_src_port;
        udp_sink_length     <= cmd_length;
        beats_left          <= cmd_beats;
        final_be            <= cmd_be;
      end

      if (data_fire) begin
        udp_sink_valid   <= 1'b1;
        udp_sink_data    <= data;
        beats_left       <= beats_left - 16'd1;
        udp_sink_last    <= final_beat;
        udp_sink_last_be <= final_beat ? final_be : 4'b0000;
      end else if (out_fire) begin
        udp_sink_valid   <= 1'b0;
        udp_sink_last    <= 1'b0;
        udp_sink_last_be <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized bench for udp_tx_framer: a packet-level model predicts each
// beat's data, last, last_be and header from the command and word list.
module tb_udp_tx_framer;

  logic        sys_clock = 1'b0;
  logic        sys_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_ip_address;
  logic [15:0] cmd_dst_port, cmd_src_port, cmd_length;
  logic        data_valid, data_ready;
  logic [31:0] data;
  logic        udp_sink_valid, udp_sink_ready;
  logic [31:0] udp_sink_data;
  logic        udp_sink_last;
  logic [3:0]  udp_sink_last_be;
  logic [31:0] udp_sink_ip_address;
  logic [15:0] udp_sink_dst_port, udp_sink_src_port, udp_sink_length;
  logic        busy, cmd_error;

  udp_tx_framer #(.MAX_LENGTH(1472)) dut (
    .sys_clock(sys_clock), .sys_reset(sys_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ip_address(cmd_ip_address), .cmd_dst_port(cmd_dst_port),
    .cmd_src_port(cmd_src_port), .cmd_length(cmd_length),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .udp_sink_valid(udp_sink_valid), .udp_sink_ready(udp_sink_ready),
    .udp_sink_data(udp_sink_data), .udp_sink_last(udp_sink_last),
    .udp_sink_last_be(udp_sink_last_be),
    .udp_sink_ip_address(udp_sink_ip_address),
    .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_src_port(udp_sink_src_port),
    .udp_sink_length(udp_sink_length), .busy(busy), .cmd_error(cmd_error)
  );

  initial forever #5 sys_clock = ~sys_clock;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [3:0]  be;
    logic [79:0] hdr;
  } beat_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       beats_q[$];
  logic [31:0] words_q[$];
  logic [31:0] pkt_words[$];
  bit          ready_pat[$];
  bit          rand_ready = 0;
  int          stall_viol = 0;

  // Downstream ready: scripted pattern consumed on valid cycles, else 1 or random.
  initial begin
    udp_sink_ready = 1'b1;
    forever begin
      @(posedge sys_clock); #1;
      if (ready_pat.size() > 0 && udp_sink_valid) udp_sink_ready = ready_pat.pop_front();
      else if (rand_ready) udp_sink_ready = ($urandom_range(0, 3) != 0);
      else udp_sink_ready = 1'b1;
    end
  end

  // Beat collector and stall-stability watcher, sampled mid-cycle.
  initial begin
    logic         prev_stall;
    logic [117:0] snap, cur;
    prev_stall = 1'b0;
    snap = '0;
    forever begin
      @(negedge sys_clock);
      if (sys_reset) prev_stall = 1'b0;
      else begin
        cur = {udp_sink_valid, udp_sink_data, udp_sink_last, udp_sink_last_be,
               udp_sink_ip_address, udp_sink_dst_port, udp_sink_src_port, udp_sink_length};
        if (prev_stall && cur !== snap) stall_viol++;
        if (udp_sink_valid && udp_sink_ready)
          beats_q.push_back('{udp_sink_data, udp_sink_last, udp_sink_last_be, cur[79:0]});
        prev_stall = udp_sink_valid && !udp_sink_ready;
        snap = cur;
      end
    end
  end

  function automatic logic [3:0] model_be(input int len);
    case (len % 4)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic send_cmd(input logic [31:0] ip, input logic [15:0] dst, input logic [15:0] src,
                          input logic [15:0] len, output bit ok);
    cmd_ip_address = ip; cmd_dst_port = dst; cmd_src_port = src; cmd_length = len;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge sys_clock);
      ok = cmd_ready;
      @(posedge sys_clock); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drive_words(input bit gaps, output bit ok);
    bit acc;
    for (int i = 0; i < 5000 && words_q.size() > 0; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        data_valid = 1'b0;
        @(posedge sys_clock); #1;
      end else begin
        data_valid = 1'b1;
        data = words_q[0];
        @(negedge sys_clock);
        acc = data_ready;
        @(posedge sys_clock); #1;
        if (acc) void'(words_q.pop_front());
      end
    end
    data_valid = 1'b0;
    ok = (words_q.size() == 0);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge sys_clock);
      ok = !busy;
    end
    @(posedge sys_clock); #1;
  endtask

  // Sends one command with pkt_words and compares the collected beats with the model.
  task automatic send_and_score_packet(input logic [31:0] ip, input logic [15:0] dst,
                                       input logic [15:0] src, input int len, input bit gaps);
    bit          ok;
    int          nb;
    logic [79:0] exp_hdr;
    logic [3:0]  exp_be;
    nb = (len + 3) / 4;
    exp_hdr = {ip, dst, src, len[15:0]};
    beats_q.delete();
    words_q = pkt_words;
    send_cmd(ip, dst, src, len[15:0], ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL cmd_accept len=%0d: accepted=%0d required=1", len, ok); end
    drive_words(gaps, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL data_accept len=%0d: left=%0d required=0", len, words_q.size()); end
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL drain len=%0d: busy stuck, required idle", len); end
    n_checks++;
    if (beats_q.size() != nb) begin
      n_fail++; $display("FAIL beat_count len=%0d: got %0d required %0d", len, beats_q.size(), nb);
    end
    for (int i = 0; i < nb && i < beats_q.size(); i++) begin
      exp_be = (i == nb - 1) ? model_be(len) : 4'b0000;
      n_checks++;
      if (beats_q[i].word !== pkt_words[i] || beats_q[i].last !== (i == nb - 1) ||
          beats_q[i].be !== exp_be || beats_q[i].hdr !== exp_hdr) begin
        n_fail++;
        $display("FAIL beat len=%0d idx=%0d: got data=%h last=%b be=%b hdr=%h required data=%h last=%b be=%b hdr=%h",
                 len, i, beats_q[i].word, beats_q[i].last, beats_q[i].be, beats_q[i].hdr,
                 pkt_words[i], (i == nb - 1), exp_be, exp_hdr);
      end
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    cmd_valid = 1'b0; data_valid = 1'b0; data = '0;
    cmd_ip_address = '0; cmd_dst_port = '0; cmd_src_port = '0; cmd_length = '0;
    repeat (3) @(posedge sys_clock);
    #1;
    n_checks++;
    if ({udp_sink_valid, udp_sink_data, udp_sink_last, udp_sink_last_be, udp_sink_ip_address,
         udp_sink_dst_port, udp_sink_src_port, udp_sink_length, busy, cmd_error} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    @(negedge sys_clock); sys_reset = 1'b0;
    @(posedge sys_clock); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || data_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: got cmd_ready=%b data_ready=%b required 1 0", cmd_ready, data_ready);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    send_cmd(32'h0a000b2b, 16'd13373, 16'd50000, 16'd4, ok);
    data_valid = 1'b1; data = 32'hDEADBEEF;
    @(negedge sys_clock);
    n_checks++;
    if (ok !== 1'b1 || data_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got accept=%b data_ready=%b required 1 1", ok, data_ready);
    end
    @(posedge sys_clock); #1;
    data_valid = 1'b0;
    n_checks++;
    if ({udp_sink_valid, udp_sink_data, udp_sink_last, udp_sink_last_be, busy} !== {1'b1, 32'hDEADBEEF, 1'b1, 4'b1000, 1'b1} ||
        {udp_sink_ip_address, udp_sink_dst_port, udp_sink_src_port, udp_sink_length} !== {32'h0a000b2b, 16'd13373, 16'd50000, 16'd4}) begin
      n_fail++;
      $display("FAIL single_beat: got v=%b d=%h l=%b be=%b busy=%b ip=%h dst=%0d src=%0d len=%0d required 1 DEADBEEF 1 1000 1 0a000b2b 13373 50000 4",
               udp_sink_valid, udp_sink_data, udp_sink_last, udp_sink_last_be, busy,
               udp_sink_ip_address, udp_sink_dst_port, udp_sink_src_port, udp_sink_length);
    end
    @(posedge sys_clock); #1;
    n_checks++;
    if (udp_sink_valid !== 1'b0 || busy !== 1'b0 || udp_sink_length !== 16'd4) begin
      n_fail++; $display("FAIL single_done: got valid=%b busy=%b len=%0d required 0 0 4", udp_sink_valid, busy, udp_sink_length);
    end
  endtask

  task automatic test_two_words();
    pkt_words = '{32'h11111111, 32'h22222222};
    send_and_score_packet(32'hc0a80001, 16'd1234, 16'd5678, 6, 0);
  endtask

  task automatic test_stall();
    pkt_words = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    ready_pat = '{1, 0, 0, 1};
    stall_viol = 0;
    send_and_score_packet(32'h0a0a0a0a, 16'd80, 16'd8080, 16, 0);
    n_checks++;
    if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes required 0", stall_viol); end
    ready_pat.delete();
  endtask

  task automatic test_reject();
    bit ok;
    logic [15:0] bad_len[2] = '{16'd0, 16'd1473};
    foreach (bad_len[k]) begin
      beats_q.delete();
      send_cmd(32'h01020304, 16'd1, 16'd2, bad_len[k], ok);
      n_checks++;
      if (ok !== 1'b1 || cmd_error !== 1'b1 || busy !== 1'b0 || udp_sink_valid !== 1'b0) begin
        n_fail++; $display("FAIL reject_pulse len=%0d: got acc=%b err=%b busy=%b valid=%b required 1 1 0 0",
                           bad_len[k], ok, cmd_error, busy, udp_sink_valid);
      end
      @(posedge sys_clock); #1;
      n_checks++;
      if (cmd_error !== 1'b0 || busy !== 1'b0 || beats_q.size() != 0) begin
        n_fail++; $display("FAIL reject_after len=%0d: got err=%b busy=%b beats=%0d required 0 0 0",
                           bad_len[k], cmd_error, busy, beats_q.size());
      end
    end
    pkt_words = '{$urandom()};
    send_and_score_packet(32'h05060708, 16'd9, 16'd10, 1, 0);
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    send_cmd(32'h0b0b0b0b, 16'd77, 16'd88, 16'd16, ok);
    words_q = '{32'h1, 32'h2};
    drive_words(0, ok);
    n_checks++;
    if (ok !== 1'b1 || udp_sink_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got acc=%b valid=%b required 1 1", ok, udp_sink_valid);
    end
    sys_reset = 1'b1;
    #1;
    n_checks++;
    if ({udp_sink_valid, udp_sink_data, udp_sink_last, udp_sink_last_be, udp_sink_ip_address,
         udp_sink_dst_port, udp_sink_src_port, udp_sink_length, busy, cmd_error} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b busy=%b len=%0d required all 0", udp_sink_valid, busy, udp_sink_length);
    end
    @(negedge sys_clock); sys_reset = 1'b0;
    @(posedge sys_clock); #1;
    pkt_words = '{32'hCAFEF00D, 32'h0BADBEEF};
    send_and_score_packet(32'h0c0c0c0c, 16'd3, 16'd4, 8, 0);
  endtask

  task automatic test_random();
    int len;
    rand_ready = 1;
    for (int p = 0; p < 8; p++) begin
      len = (p == 7) ? 1472 : int'($urandom_range(1, 64));
      pkt_words.delete();
      for (int w = 0; w < (len + 3) / 4; w++) pkt_words.push_back($urandom());
      send_and_score_packet($urandom(), 16'($urandom()), 16'($urandom()), len, 1);
    end
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_stall();
    test_reject();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
